leb128_packer: RTL and testbench

LEB128_PACKER -- requirements
Module: leb128_packer

---
 rtl/leb128_packer.sv | 111 +++++++++++
 tb/tb_leb128_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_packer.sv
// Streams a 32/64-bit integer operand out as signed LEB128 bytes, one per accepted cycle.
// Optional unsigned encoding is enabled by defining LEB128_UNSIGNED_EN (adds in_unsigned).
module leb128_packer #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic [1:0]       in_type,
`ifdef LEB128_UNSIGNED_EN
   input  logic             in_unsigned,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [LEN_W-1:0] out_len,
   output logic             error
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [63:0]      value;
   logic [63:0]      loaded;
   logic [63:0]      shifted;
   logic [LEN_W-1:0] count;
   logic             uns_q;
   logic             uns_in;
   logic             error_q;
   logic             accept;
   logic             reject;
   logic             cont;

`ifdef LEB128_UNSIGNED_EN
   assign uns_in = in_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   // Float operand types are refused outright: they pulse error and never leave IDLE.
   assign accept = in_valid && (state == IDLE) && !in_type[1];
   assign reject = in_valid && (state == IDLE) && in_type[1];

   always_comb begin
      loaded = in_data;
      if (!in_type[0]) begin
         if (uns_in)
            loaded = {32'h0, in_data[31:0]};
         else
            loaded = {{32{in_data[31]}}, in_data[31:0]};
      end
   end

   // The encoding terminates once the remaining value carries no information beyond the sign in bit 6.
   always_comb begin
      shifted = uns_q ? {7'h00, value[63:7]} : {{7{value[63]}}, value[63:7]};
      if (uns_q)
         cont = |shifted;
      else
         cont = !(((shifted == 64'h0) && !value[6]) || ((&shifted) && value[6]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EMIT;
         EMIT:    if (out_ready && !cont) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value   <= 64'h0;
         count   <= '0;
         uns_q   <= 1'b0;
         error_q <= 1'b0;
      end else begin
         error_q <= reject;
         if (accept) begin
            value <= loaded;
            count <= '0;
            uns_q <= uns_in;
         end else if ((state == EMIT) && out_ready && cont) begin
            value <= shifted;
            count <= count + LEN_W'(1);
         end
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == EMIT);
      out_data  = out_valid ? {cont, value[6:0]} : 8'h00;
      out_last  = out_valid && !cont;
      out_len   = out_valid ? count + LEN_W'(1) : '0;
      error     = error_q;
   end

endmodule

// File: tb/tb_leb128_packer.sv
// Self-checking bench for leb128_packer: directed corner operands plus random operands
// compared against an arithmetic LEB128 reference encoder.
module tb_leb128_packer;

   localparam int LEN_W = 4;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_data;
   logic [1:0]       in_type;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic [LEN_W-1:0] out_len;
   logic             error;
`ifdef LEB128_UNSIGNED_EN
   logic             in_unsigned;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          got_len;
   logic [63:0] got_pack;
   bit          cur_uns = 1'b0;

   leb128_packer #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_type   (in_type),
`ifdef LEB128_UNSIGNED_EN
      .in_unsigned(in_unsigned),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_len   (out_len),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference LEB128 encoder: peel 7 bits at a time until the rest is pure sign (or zero).
   function automatic void model(input logic [63:0] d, input logic [1:0] t, input bit uns);
      longint          v;
      longint unsigned u;
      int              s;
      logic [7:0]      b;
      bit              done;
      exp_q.delete();
      if (t == 2'b00) begin
         s = d[31:0];
         v = uns ? longint'({32'h0, d[31:0]}) : longint'(s);
      end else begin
         v = d;
      end
      u = v;
      do begin
         if (uns) begin
            b    = {1'b0, u[6:0]};
            u    = u >> 7;
            done = (u == 0);
         end else begin
            b    = {1'b0, v[6:0]};
            v    = v >>> 7;
            done = ((v == 0) && !b[6]) || ((v == -1) && b[6]);
         end
         b[7] = !done;
         exp_q.push_back(b);
      end while (!done);
   endfunction

   task automatic applyStimulus(input logic [63:0] d, input logic [1:0] t);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_type  = t;
`ifdef LEB128_UNSIGNED_EN
      in_unsigned = cur_uns;
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   // mode 0: always ready, 1: ready every other cycle, 2: random ready
   task automatic collect(input int mode, input int max_bytes);
      bit         done = 1'b0;
      bit         stalled = 1'b0;
      logic [7:0] held = 8'h00;
      got_q.delete();
      got_len  = 0;
      got_pack = 64'h0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = $urandom_range(0, 1);
         endcase
         #1;
         if (cyc == 0) checkOutput("first_byte_latency", out_valid, 1);
         if (out_valid) checkOutput("in_ready_low_in_emit", in_ready, 0);
         if (stalled) checkOutput("hold_data", out_data, held);
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (got_q.size() <= 8) got_pack = (got_pack << 8) | 64'(out_data);
            if (out_last) begin
               got_len = out_len;
               done    = 1'b1;
            end
            if (got_q.size() >= max_bytes) done = 1'b1;
         end
         if (done) @(posedge clk);
      end
      if (!done) checkOutput("collect_timeout", 0, 1);
   endtask

   task automatic run_op(input string tag, input logic [63:0] d, input logic [1:0] t, input int mode);
      model(d, t, cur_uns);
      applyStimulus(d, t);
      collect(mode, 16);
      checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         checkOutput({tag, "_byte"}, got_q[i], exp_q[i]);
      checkOutput({tag, "_len"}, got_len, exp_q.size());
      @(negedge clk);
      #1;
      checkOutput({tag, "_in_ready_after"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] d;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 64'h0;
      in_type   = 2'b00;
      out_ready = 1'b0;
`ifdef LEB128_UNSIGNED_EN
      in_unsigned = 1'b0;
`endif
      #23;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_out_last", out_last, 0);
      checkOutput("reset_out_len", out_len, 0);
      checkOutput("reset_error", error, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      reset = 1'b0;

      run_op("i32_zero", 64'h0, 2'b00, 0);
      checkOutput("i32_zero_const", got_pack, 64'h00);
      run_op("i32_ones", 64'h1234_5678_FFFF_FFFF, 2'b00, 0);
      checkOutput("i32_ones_const", got_pack, 64'h7F);
      run_op("i64_neg", 64'(-123456), 2'b01, 0);
      checkOutput("i64_neg_const", got_pack, 64'hC0BB78);
      run_op("i32_min", 64'h8000_0000, 2'b00, 2);
      checkOutput("i32_min_const", got_pack, 64'h80_8080_8078);
      run_op("i64_max", 64'h7FFF_FFFF_FFFF_FFFF, 2'b01, 0);
      checkOutput("i64_max_head", got_pack, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("i64_max_toggle", 64'h7FFF_FFFF_FFFF_FFFF, 2'b01, 1);
      checkOutput("i64_max_toggle_tail", got_q[got_q.size()-1], 8'h00);

      // Rejected float operand
      applyStimulus(64'h3F80_0000, 2'b10);
      @(negedge clk);
      #1;
      checkOutput("f32_error_pulse", error, 1);
      checkOutput("f32_no_valid", out_valid, 0);
      checkOutput("f32_in_ready", in_ready, 1);
      @(negedge clk);
      #1;
      checkOutput("f32_error_once", error, 0);
      checkOutput("f32_still_idle", out_valid, 0);

      // Reset in the middle of a 5-byte encoding
      applyStimulus(64'h8000_0000, 2'b00);
      collect(0, 2);
      checkOutput("midreset_partial", got_q.size(), 2);
      @(negedge clk);
      out_ready = 1'b0;
      reset     = 1'b1;
      #1;
      checkOutput("midreset_out_valid", out_valid, 0);
      checkOutput("midreset_out_data", out_data, 0);
      checkOutput("midreset_out_last", out_last, 0);
      checkOutput("midreset_out_len", out_len, 0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", 64'h5, 2'b00, 0);
      checkOutput("after_reset_const", got_pack, 64'h05);

`ifdef LEB128_UNSIGNED_EN
      cur_uns = 1'b1;
      run_op("u32_64", 64'd64, 2'b00, 0);
      checkOutput("u32_64_const", got_pack, 64'h40);
      run_op("u32_ones", 64'hFFFF_FFFF, 2'b00, 1);
      checkOutput("u32_ones_const", got_pack, 64'hFF_FFFF_FF0F);
      cur_uns = 1'b0;
      run_op("s32_64", 64'd64, 2'b00, 0);
      checkOutput("s32_64_const", got_pack, 64'hC000);
`endif

      for (int k = 0; k < 40; k++) begin
         d = {$urandom, $urandom};
         d = d >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) d = ~d;
`ifdef LEB128_UNSIGNED_EN
         cur_uns = $urandom_range(0, 1);
`endif
         run_op("rand", d, 2'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
